// File: rtl/life_grid_engine.sv
// Life grid engine: MxN cellular automaton with run-time B/S masks, torus or bounded edges,
// row loading, run/step FSM (IDLE/RUN/HALT), saturating generation counter, still-life halt.
// Ports: clk_i, reset_n_i (async, active-low), load_i/load_row_i/load_data_i, run_i, step_i,
// birth_mask_i, survive_mask_i, wrap_i -> state_o, gen_count_o, busy_o, stable_o, extinct_o.
// Optional macro LIFE_OSC_DETECT_EN adds osc_o and period-2 oscillation halt.
module life_grid_engine #(
  parameter int M     = 16,
  parameter int N     = 16,
  parameter int GEN_W = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 load_i,
  input  logic [$clog2(N)-1:0] load_row_i,
  input  logic [M-1:0]         load_data_i,
  input  logic                 run_i,
  input  logic                 step_i,
  input  logic [8:0]           birth_mask_i,
  input  logic [8:0]           survive_mask_i,
  input  logic                 wrap_i,
  output logic [N*M-1:0]       state_o,
  output logic [GEN_W-1:0]     gen_count_o,
  output logic                 busy_o,
  output logic                 stable_o,
  output logic                 extinct_o
`ifdef LIFE_OSC_DETECT_EN
  ,
  output logic                 osc_o
`endif
);

  localparam int W  = N * M;
  localparam int RW = $clog2(N);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } fsm_e;

  fsm_e             fsm_q, fsm_d;
  logic [W-1:0]     state_q, state_d;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic [W-1:0]     nxt;
  logic             same;
  logic             upd;
  logic             load_ok;
  logic             osc_hit;

  for (genvar gy = 0; gy < N; gy++) begin : g_row
    for (genvar gx = 0; gx < M; gx++) begin : g_col
      localparam int XL = (gx + M - 1) % M;
      localparam int XR = (gx + 1) % M;
      localparam int YU = (gy + N - 1) % N;
      localparam int YD = (gy + 1) % N;
      localparam int C  = gy * M + gx;
      logic       ok_l, ok_r, ok_u, ok_d;
      logic [7:0] nb;
      logic [3:0] cnt;
      // Edge neighbours only count when wrapping or genuinely inside the grid.
      assign ok_l = wrap_i | (gx != 0);
      assign ok_r = wrap_i | (gx != M - 1);
      assign ok_u = wrap_i | (gy != 0);
      assign ok_d = wrap_i | (gy != N - 1);
      assign nb = {
        state_q[YU*M+XL] & ok_u & ok_l,
        state_q[YU*M+gx] & ok_u,
        state_q[YU*M+XR] & ok_u & ok_r,
        state_q[gy*M+XL] & ok_l,
        state_q[gy*M+XR] & ok_r,
        state_q[YD*M+XL] & ok_d & ok_l,
        state_q[YD*M+gx] & ok_d,
        state_q[YD*M+XR] & ok_d & ok_r
      };
      assign cnt = 4'($countones(nb));
      assign nxt[C] = state_q[C] ? survive_mask_i[cnt]
                                 : birth_mask_i[cnt];
    end
  end

  assign same    = (nxt == state_q);
  assign load_ok = load_i && (32'(load_row_i) < 32'(N));

`ifdef LIFE_OSC_DETECT_EN
  logic [W-1:0] hist_q, hist_d;
  logic         hist_vld_q, hist_vld_d;
  logic         osc_q, osc_d;
  // hist_q holds the grid as it was before the previous update.
  assign osc_hit = hist_vld_q && (nxt == hist_q) && !same;
`else
  assign osc_hit = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    fsm_d    = fsm_q;
    upd      = 1'b0;
`ifdef LIFE_OSC_DETECT_EN
    hist_d     = hist_q;
    hist_vld_d = hist_vld_q;
    osc_d      = osc_q;
`endif
    if (load_ok) begin
      for (int r = 0; r < N; r++) begin
        if (load_row_i == RW'(r)) state_d[r*M +: M] = load_data_i;
      end
      gen_d    = '0;
      stable_d = 1'b0;
      fsm_d    = S_IDLE;
`ifdef LIFE_OSC_DETECT_EN
      hist_vld_d = 1'b0;
      osc_d      = 1'b0;
`endif
    end else begin
      unique case (fsm_q)
        S_IDLE: begin
          if (run_i)       fsm_d = S_RUN;
          else if (step_i) upd   = 1'b1;
        end
        S_RUN: begin
          if (!run_i) begin
            fsm_d = S_IDLE;
          end else begin
            upd = 1'b1;
            if (same || osc_hit) fsm_d = S_HALT;
          end
        end
        S_HALT: begin
          if (!run_i) fsm_d = S_IDLE;
        end
        default: fsm_d = S_IDLE;
      endcase
      if (upd) begin
        state_d  = nxt;
        stable_d = same;
        if (gen_q != '1) gen_d = gen_q + 1'b1;
`ifdef LIFE_OSC_DETECT_EN
        hist_d     = state_q;
        hist_vld_d = 1'b1;
        osc_d      = osc_hit;
`endif
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
      fsm_q    <= S_IDLE;
`ifdef LIFE_OSC_DETECT_EN
      hist_q     <= '0;
      hist_vld_q <= 1'b0;
      osc_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
      fsm_q    <= fsm_d;
`ifdef LIFE_OSC_DETECT_EN
      hist_q     <= hist_d;
      hist_vld_q <= hist_vld_d;
      osc_q      <= osc_d;
`endif
    end
  end

  assign state_o     = state_q;
  assign gen_count_o = gen_q;
  assign busy_o      = (fsm_q == S_RUN);
  assign stable_o    = stable_q;
  assign extinct_o   = ~|state_q;
`ifdef LIFE_OSC_DETECT_EN
  assign osc_o = osc_q;
`endif

endmodule

// File: tb/tb_life_grid_engine.sv
// Bench for life_grid_engine: 16x16 main instance plus 5x5/3-bit-gen
// instance for out-of-range row and counter saturation.
module tb_life_grid_engine;

  localparam int M = 16;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [3:0]   row = '0;
  logic [15:0]  data = '0;
  logic         run = 1'b0;
  logic         step = 1'b0;
  logic [8:0]   bmask = 9'h008;
  logic [8:0]   smask = 9'h00C;
  logic         wrap = 1'b1;
  logic [255:0] state;
  logic [15:0]  gen;
  logic         busy, stable, extinct;

  logic         s_load = 1'b0;
  logic [2:0]   s_row = '0;
  logic [4:0]   s_data = '0;
  logic         s_run = 1'b0;
  logic         s_step = 1'b0;
  logic [24:0]  s_state;
  logic [2:0]   s_gen;
  logic         s_busy, s_stable, s_extinct;
`ifdef LIFE_OSC_DETECT_EN
  logic         osc, s_osc;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  life_grid_engine #(.M(16), .N(16), .GEN_W(16)) u_dut (
    .clk_i(clk), .reset_n_i(rst_n),
    .load_i(load), .load_row_i(row), .load_data_i(data),
    .run_i(run), .step_i(step),
    .birth_mask_i(bmask), .survive_mask_i(smask), .wrap_i(wrap),
    .state_o(state), .gen_count_o(gen), .busy_o(busy),
    .stable_o(stable), .extinct_o(extinct)
`ifdef LIFE_OSC_DETECT_EN
    , .osc_o(osc)
`endif
  );

  life_grid_engine #(.M(5), .N(5), .GEN_W(3)) u_small (
    .clk_i(clk), .reset_n_i(rst_n),
    .load_i(s_load), .load_row_i(s_row), .load_data_i(s_data),
    .run_i(s_run), .step_i(s_step),
    .birth_mask_i(bmask), .survive_mask_i(smask), .wrap_i(wrap),
    .state_o(s_state), .gen_count_o(s_gen), .busy_o(s_busy),
    .stable_o(s_stable), .extinct_o(s_extinct)
`ifdef LIFE_OSC_DETECT_EN
    , .osc_o(s_osc)
`endif
  );

  // Reference: count live cells in the 8-neighbourhood by coordinates.
  function automatic int nbrs(bit [255:0] g, int m, int n, int x, int y,
                              bit wr);
    int k = 0;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++) begin
        int xx = x + dx;
        int yy = y + dy;
        if (dx == 0 && dy == 0) continue;
        if (wr) begin
          xx = (xx + m) % m;
          yy = (yy + n) % n;
        end
        if (xx >= 0 && xx < m && yy >= 0 && yy < n && g[yy*m+xx]) k++;
      end
    return k;
  endfunction

  function automatic bit [255:0] model_next(bit [255:0] g, int m, int n,
                                            bit [8:0] bm, bit [8:0] sm,
                                            bit wr);
    bit [255:0] r = '0;
    for (int y = 0; y < n; y++)
      for (int x = 0; x < m; x++) begin
        int k = nbrs(g, m, n, x, y, wr);
        r[y*m+x] = g[y*m+x] ? sm[k] : bm[k];
      end
    return r;
  endfunction

  function automatic bit [255:0] glider_seed();
    bit [255:0] g = '0;
    g[1*16+2] = 1'b1;
    g[2*16+3] = 1'b1;
    g[3*16+1] = 1'b1;
    g[3*16+2] = 1'b1;
    g[3*16+3] = 1'b1;
    return g;
  endfunction

  function automatic bit [255:0] rand_grid(bit sparse);
    bit [255:0] g;
    for (int w = 0; w < 8; w++) begin
      g[w*32 +: 32] = $urandom;
      if (sparse) g[w*32 +: 32] = g[w*32 +: 32] & $urandom;
    end
    return g;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic load_grid(input bit [255:0] g);
    for (int r = 0; r < N; r++) begin
      load = 1'b1;
      row  = r[3:0];
      data = g[r*16 +: 16];
      tick();
    end
    load = 1'b0;
  endtask

  task automatic do_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (state !== '0) begin bad++;
      $display("FAIL reset_state got=%h want=0", state); end
    total++; if (gen !== 16'd0) begin bad++;
      $display("FAIL reset_gen got=%0d want=0", gen); end
    total++; if (stable !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_flags stable=%b busy=%b want=0,0", stable, busy); end
    total++; if (extinct !== 1'b1) begin bad++;
      $display("FAIL reset_extinct got=%b want=1", extinct); end
    total++; if (s_state !== '0 || s_gen !== 3'd0) begin bad++;
      $display("FAIL reset_small got=%h/%0d want=0/0", s_state, s_gen); end
`ifdef LIFE_OSC_DETECT_EN
    total++; if (osc !== 1'b0) begin bad++;
      $display("FAIL reset_osc got=%b want=0", osc); end
`endif
  endtask

  task automatic test_random_step();
    bit [255:0] cur, exp;
    for (int it = 0; it < 14; it++) begin
      cur = rand_grid(it[0]);
      wrap = 1'($urandom);
      load_grid(cur);
      total++; if (state !== cur) begin bad++;
        $display("FAIL rand_load it=%0d got=%h want=%h", it, state, cur); end
      for (int s = 1; s <= 3; s++) begin
        if (it % 3 == 0) begin
          bmask = 9'h008;
          smask = 9'h00C;
        end else begin
          bmask = 9'($urandom);
          smask = 9'($urandom);
        end
        exp = model_next(cur, M, N, bmask, smask, wrap);
        do_step();
        total++; if (state !== exp) begin bad++;
          $display("FAIL rand_step it=%0d s=%0d got=%h want=%h",
                   it, s, state, exp); end
        total++; if (gen !== 16'(s) || busy !== 1'b0) begin bad++;
          $display("FAIL rand_gen it=%0d got=%0d busy=%b want=%0d busy=0",
                   it, gen, busy, s); end
        total++; if (stable !== (exp == cur)) begin bad++;
          $display("FAIL rand_stable it=%0d got=%b want=%b",
                   it, stable, exp == cur); end
        total++; if (extinct !== (exp == '0)) begin bad++;
          $display("FAIL rand_extinct it=%0d got=%b want=%b",
                   it, extinct, exp == '0); end
        cur = exp;
      end
    end
  endtask

  task automatic test_glider_wrap();
    bit [255:0] g, sh;
    bit hit = 0;
    g = glider_seed();
    sh = '0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < M; x++)
        if (g[y*M+x]) sh[((y+1)%N)*M + (x+1)%M] = 1'b1;
    bmask = 9'h008; smask = 9'h00C; wrap = 1'b1;
    load_grid(g);
    for (int i = 0; i < 4; i++) do_step();
    total++; if (state !== sh || gen !== 16'd4) begin bad++;
      $display("FAIL glider_shift got=%h gen=%0d want=%h gen=4",
               state, gen, sh); end
    run = 1'b1;
    for (int c = 0; c < 200; c++) begin
      tick();
      if (gen == 16'd64) begin hit = 1; break; end
    end
    run = 1'b0;
    total++; if (!hit) begin bad++;
      $display("FAIL glider_run_timeout gen=%0d want=64", gen); end
    tick();
    total++; if (state !== g || gen !== 16'd64) begin bad++;
      $display("FAIL glider_64 got=%h gen=%0d want=%h gen=64", state, gen, g); end
    total++; if (stable !== 1'b0 || busy !== 1'b0) begin bad++;
      $display("FAIL glider_64_flags stable=%b busy=%b want=0,0", stable, busy); end
  endtask

  task automatic test_block_halt();
    bit [255:0] blk = '0;
    bit hit = 0;
    blk[5*16+5] = 1; blk[5*16+6] = 1; blk[6*16+5] = 1; blk[6*16+6] = 1;
    bmask = 9'h008; smask = 9'h00C; wrap = 1'b1;
    load_grid(blk);
    run = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (stable) begin hit = 1; break; end
    end
    tick(); tick();
    total++; if (!hit) begin bad++;
      $display("FAIL block_timeout stable=%b want=1", stable); end
    total++; if (gen !== 16'd1 || busy !== 1'b0 || stable !== 1'b1) begin bad++;
      $display("FAIL block_halt gen=%0d busy=%b stable=%b want 1,0,1",
               gen, busy, stable); end
    total++; if (state !== blk) begin bad++;
      $display("FAIL block_grid got=%h want=%h", state, blk); end
    run = 1'b0;
    tick();
    do_step();
    total++; if (gen !== 16'd2 || busy !== 1'b0 || state !== blk) begin bad++;
      $display("FAIL block_idle_step gen=%0d busy=%b want gen=2 busy=0",
               gen, busy); end
  endtask

  task automatic test_bounded_glider();
    bit [255:0] cur, nx;
    int n = 0;
    int viol = 0;
    bit hit = 0;
    bmask = 9'h008; smask = 9'h00C; wrap = 1'b0;
    cur = glider_seed();
    for (int i = 0; i < 200; i++) begin
      nx = model_next(cur, M, N, bmask, smask, 1'b0);
      n++;
      if (nx == cur) break;
      cur = nx;
    end
    load_grid(glider_seed());
    run = 1'b1;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (stable) begin hit = 1; break; end
    end
    tick(); tick();
    total++; if (!hit) begin bad++;
      $display("FAIL bounded_timeout gen=%0d want halt", gen); end
    total++; if (state !== cur || gen !== 16'(n)) begin bad++;
      $display("FAIL bounded_final got=%h gen=%0d want=%h gen=%0d",
               state, gen, cur, n); end
    total++; if (busy !== 1'b0 || stable !== 1'b1) begin bad++;
      $display("FAIL bounded_halt busy=%b stable=%b want 0,1", busy, stable); end
    run = 1'b0;
    tick();
    wrap = 1'b1;
    load_grid(glider_seed());
    run = 1'b1;
    tick(); tick();
    for (int c = 0; c < 200; c++) begin
      tick();
      if (stable || !busy) viol++;
    end
    total++; if (viol != 0) begin bad++;
      $display("FAIL torus_no_halt violations=%0d want=0", viol); end
    run = 1'b0;
    tick();
  endtask

  task automatic test_highlife();
    bit [255:0] seed = '0;
    bit [255:0] c1, h1, dif;
    seed[7*16+7] = 1; seed[7*16+8] = 1; seed[7*16+9] = 1;
    seed[9*16+7] = 1; seed[9*16+8] = 1; seed[9*16+9] = 1;
    wrap = 1'b1;
    dif = '0;
    for (int y = 0; y < N; y++)
      for (int x = 0; x < M; x++)
        if (nbrs(seed, M, N, x, y, 1'b1) == 6) dif[y*M+x] = 1'b1;
    bmask = 9'h008; smask = 9'h00C;
    load_grid(seed);
    do_step();
    c1 = state;
    total++; if (c1 !== model_next(seed, M, N, 9'h008, 9'h00C, 1'b1)) begin
      bad++; $display("FAIL conway_gen1 got=%h", c1); end
    bmask = 9'h048;
    load_grid(seed);
    do_step();
    h1 = state;
    total++; if ((c1 ^ h1) !== dif) begin bad++;
      $display("FAIL highlife_diff got=%h want=%h", c1 ^ h1, dif); end
    bmask = 9'h008;
  endtask

  task automatic test_load_midrun();
    bit [255:0] prev;
    bmask = 9'h008; smask = 9'h00C; wrap = 1'b1;
    load_grid(rand_grid(1'b0));
    run = 1'b1;
    for (int c = 0; c < 5; c++) tick();
    prev = state;
    prev[3*16 +: 16] = 16'hFFFF;
    load = 1'b1; row = 4'd3; data = 16'hFFFF;
    tick();
    load = 1'b0;
    run = 1'b0;
    total++; if (busy !== 1'b0 || gen !== 16'd0 || stable !== 1'b0) begin
      bad++; $display("FAIL load_mid busy=%b gen=%0d stable=%b want 0,0,0",
                      busy, gen, stable); end
    total++; if (state !== prev) begin bad++;
      $display("FAIL load_mid_grid got=%h want=%h", state, prev); end
    tick();
  endtask

  task automatic test_small_row_sat();
    bit [255:0] cur = '0;
    bit [255:0] snap;
    bmask = 9'h008; smask = 9'h00C; wrap = 1'b1;
    for (int r = 0; r < 5; r++) begin
      s_load = 1'b1; s_row = r[2:0]; s_data = 5'($urandom);
      cur[r*5 +: 5] = s_data;
      tick();
    end
    s_load = 1'b0;
    total++; if (s_state !== cur[24:0]) begin bad++;
      $display("FAIL small_load got=%h want=%h", s_state, cur[24:0]); end
    s_step = 1'b1; tick(); s_step = 1'b0;
    cur = model_next(cur, 5, 5, bmask, smask, wrap);
    snap = cur;
    for (int r = 5; r < 8; r++) begin
      s_load = 1'b1; s_row = r[2:0]; s_data = 5'h1F;
      tick();
    end
    s_load = 1'b0;
    total++; if (s_state !== snap[24:0] || s_gen !== 3'd1) begin bad++;
      $display("FAIL small_bad_row got=%h gen=%0d want=%h gen=1",
               s_state, s_gen, snap[24:0]); end
    for (int k = 2; k <= 10; k++) begin
      s_step = 1'b1; tick(); s_step = 1'b0;
      cur = model_next(cur, 5, 5, bmask, smask, wrap);
      total++; if (s_gen !== 3'((k > 7) ? 7 : k) || s_state !== cur[24:0])
      begin bad++;
        $display("FAIL small_sat k=%0d gen=%0d st=%h want gen=%0d st=%h",
                 k, s_gen, s_state, (k > 7) ? 7 : k, cur[24:0]); end
    end
  endtask

  task automatic test_reset_midrun();
    load_grid(rand_grid(1'b0));
    run = 1'b1;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    total++; if (state !== '0 || gen !== 16'd0 || busy !== 1'b0) begin bad++;
      $display("FAIL reset_mid state=%h gen=%0d busy=%b want 0", state, gen, busy); end
    run = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_blinker();
    bit hit = 0;
    bit [255:0] g = '0;
    g[4*16 +: 16] = 16'h0070;
    bmask = 9'h008; smask = 9'h00C; wrap = 1'b1;
    load_grid(g);
    run = 1'b1;
`ifdef LIFE_OSC_DETECT_EN
    for (int c = 0; c < 20; c++) begin
      tick();
      if (osc) begin hit = 1; break; end
    end
    tick(); tick();
    total++; if (!hit || gen !== 16'd2 || busy !== 1'b0 || stable !== 1'b0)
    begin bad++;
      $display("FAIL blinker_osc osc=%b gen=%0d busy=%b want osc gen=2 busy=0",
               hit, gen, busy); end
    total++; if (state !== g) begin bad++;
      $display("FAIL blinker_osc_grid got=%h want=%h", state, g); end
`else
    for (int c = 0; c < 10; c++) begin
      tick();
      if (gen == 16'd1) begin hit = 1; break; end
    end
    total++; if (!hit) begin bad++;
      $display("FAIL blinker_start gen=%0d want=1", gen); end
    for (int c = 0; c < 8; c++) begin
      int g0 = int'(gen);
      tick();
      total++; if (int'(gen) != g0 + 1 || busy !== 1'b1) begin bad++;
        $display("FAIL blinker_run gen=%0d busy=%b want gen=%0d busy=1",
                 gen, busy, g0 + 1); end
    end
`endif
    run = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_random_step();
    test_glider_wrap();
    test_block_halt();
    test_bounded_glider();
    test_highlife();
    test_load_midrun();
    test_small_row_sat();
    test_reset_midrun();
    test_blinker();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
